exwb_wb_drain: RTL and testbench
================================

Name: exwb_wb_drain

Overview:
- Writeback-side consumer of the EX/WB interface; the execute-side select mux is its producer.
- Buffers execute results in a small FIFO and sequences them onto the single register-file write port, one register per cycle.
- Splits double-width results into two consecutive writes and stalls when the write port is lent to another writer.
- Exposes a forwarding lookup so decode/execute can read results that are still in flight.

Parameters:
- DATA_WIDTH, 32, register width in bits.
- REG_ADDR_WIDTH, 5, register index width.
- DEPTH, 2, FIFO entries; must be a power of two, at least 2.

Ports:
- clock  in  1  system clock; rising edge.
- reset  in  1  asynchronous, active-low reset.
- ex_valid  in  1  execute presents a result.
- ex_ready  out  1  buffer can accept a result.
- ex_rd  in  REG_ADDR_WIDTH  destination register.
- ex_wide  in  1  result writes ex_rd and ex_rd+1.
- ex_data  in  2*DATA_WIDTH  result; low half goes to ex_rd, high half to ex_rd+1.
- rf_stall  in  1  write port is owned by another writer this cycle.
- rf_we  out  1  register-file write enable.
- rf_waddr  out  REG_ADDR_WIDTH  write address.
- rf_wdata  out  DATA_WIDTH  write data.
- q_addr  in  REG_ADDR_WIDTH  forwarding lookup address.
- q_hit  out  1  lookup matches an in-flight result.
- q_data  out  DATA_WIDTH  forwarded data.
- retire_count  out  32  count of fully retired results.

Behaviour:
- Reset (reset=0, asynchronous):
  - FIFO empty, FSM in IDLE.
  - ex_ready=1, rf_we=0, rf_waddr=0, rf_wdata=0, q_hit=0, q_data=0, retire_count=0.
  - Deassertion is synchronous to clock. An entry caught mid-sequence is discarded, including a pending high half.
- Accept:
  - A result is pushed when ex_valid & ex_ready at a rising edge.
  - ex_ready = !full, decoded from registered state only. No push when full, even if a pop occurs in the same cycle.
- FSM, acting on the head entry:
  - IDLE: FIFO empty. Go to LO when non-empty.
  - LO: drive rf_waddr=rd and rf_wdata=data[DATA_WIDTH-1:0].
    - rf_we = !rf_stall & (rd!=0).
    - If rf_stall: hold.
    - Else, if wide: go to HI.
    - Else: pop, retire_count+1, then go to LO if entries remain, otherwise IDLE.
  - HI: drive rf_waddr=rd+1 (mod 2^REG_ADDR_WIDTH) and rf_wdata=data[2*DATA_WIDTH-1:DATA_WIDTH].
    - rf_we = !rf_stall & ((rd+1)!=0).
    - If rf_stall: hold.
    - Else: pop, retire_count+1, then next state is LO or IDLE as above.
- Writes to x0 are suppressed: rf_we=0, but the cycle is consumed and the entry retires normally. A wide write with rd=31 writes r31, then suppresses the wrapped r0.
- rf_we, rf_waddr and rf_wdata are combinational from registered state and rf_stall. They are 0 in IDLE.
- Latency: a result accepted at edge N shows rf_we=1 in the cycle after N (earliest), when the FIFO was empty and rf_stall=0.
- Throughput: one register per unstalled cycle. Narrow results sustain 1 per cycle. Wide results take 2 cycles.
- Forwarding (combinational):
  - Compare q_addr against every valid entry's rd, and against rd+1 for wide entries.
  - The youngest match wins; within one entry, the rd+1 match returns the high half.
  - q_addr=0 never hits. A head entry already in HI still matches its rd, returning the low half.
  - On a miss, q_hit=0 and q_data=0.
- retire_count: increments once per fully retired entry, including x0-suppressed entries; wraps at 2^32.
- Pointers wrap modulo DEPTH.

Test Plan:
1. After reset release, push rd=5, narrow, data low=0xDEADBEEF -> next cycle rf_we=1, rf_waddr=5, rf_wdata=0xDEADBEEF; retire_count=1; ex_ready stays 1.
2. Push rd=6, wide, data=0x11112222_33334444 -> rf_we writes r6=0x33334444, then r7=0x11112222 on consecutive cycles; retire_count increments only after the r7 write.
3. Hold rf_stall=1 and push 3 narrow results to registers 1,2,3 -> ex_ready=0 after 2 accepts and the third is held off. Release the stall -> writes r1, r2, r3 in order over 3 cycles; ex_ready returns to 1.
4. Push rd=0 narrow, then rd=31 wide -> rf_we=0 for r0, r31 written, wrapped r0 suppressed; retire_count=2.
5. Buffer rd=9 (0xA) and rd=9 (0xB) with rf_stall=1, then set q_addr=9 -> q_hit=1, q_data=0xB. With q_addr=10, q_hit=0 and q_data=0.
6. Assert reset while in HI of a wide entry with a second entry queued -> all outputs 0 immediately, ex_ready=1, and no further rf_we after release.

Source files
------------

// File: rtl/exwb_wb_drain_if.sv
// EX/WB result channel: execute-side select mux (master) to writeback drain (slave).
// valid/ready: a transfer happens on a rising edge where ex_valid & ex_ready; while ex_valid is high and ex_ready is low the master holds rd/wide/data stable.
interface exwb_wb_drain_if #(
  parameter int DATA_WIDTH     = 32,
  parameter int REG_ADDR_WIDTH = 5
);
  logic                      ex_valid;
  logic                      ex_ready;
  logic [REG_ADDR_WIDTH-1:0] ex_rd;
  logic                      ex_wide;
  logic [2*DATA_WIDTH-1:0]   ex_data;

  modport master (output ex_valid, ex_rd, ex_wide, ex_data, input ex_ready);
  modport slave  (input ex_valid, ex_rd, ex_wide, ex_data, output ex_ready);
endinterface

// File: rtl/exwb_wb_drain.sv
// Writeback drain: buffers execute results and sequences them onto the single
// register-file write port, splitting wide results; forwards in-flight results.
module exwb_wb_drain #(
  parameter int DATA_WIDTH     = 32,
  parameter int REG_ADDR_WIDTH = 5,
  parameter int DEPTH          = 2
) (
  input  logic                      clock,
  input  logic                      reset,
  exwb_wb_drain_if.slave            ex,
  input  logic                      rf_stall,
  output logic                      rf_we,
  output logic [REG_ADDR_WIDTH-1:0] rf_waddr,
  output logic [DATA_WIDTH-1:0]     rf_wdata,
  input  logic [REG_ADDR_WIDTH-1:0] q_addr,
  output logic                      q_hit,
  output logic [DATA_WIDTH-1:0]     q_data,
  output logic [31:0]               retire_count,
  output logic [1:0]                fsm_state
);
  localparam int PTR_W = $clog2(DEPTH);
  localparam logic [REG_ADDR_WIDTH-1:0] ONE = REG_ADDR_WIDTH'(1);

  typedef enum logic [1:0] {IDLE = 2'd0, LO = 2'd1, HI = 2'd2} state_t;

  state_t                    state;
  logic [REG_ADDR_WIDTH-1:0] rd_mem   [DEPTH];
  logic                      wide_mem [DEPTH];
  logic [2*DATA_WIDTH-1:0]   data_mem [DEPTH];
  logic [PTR_W:0]            wr_ptr, rd_ptr, count;
  logic [PTR_W-1:0]          head, tail, idx;
  logic                      full, push, pop, more;
  logic [REG_ADDR_WIDTH-1:0] head_rd, head_rd1;

  assign count       = wr_ptr - rd_ptr;
  assign full        = (count == (PTR_W+1)'(DEPTH));
  assign head        = rd_ptr[PTR_W-1:0];
  assign tail        = wr_ptr[PTR_W-1:0];
  assign ex.ex_ready = !full;
  assign push        = ex.ex_valid && !full;
  assign head_rd     = rd_mem[head];
  assign head_rd1    = head_rd + ONE;
  assign fsm_state   = state;
  // Entries left after this cycle's pop, counting a same-cycle push.
  assign more        = (count > (PTR_W+1)'(1)) || push;

  always_comb begin
    pop = 1'b0;
    case (state)
      LO:      pop = !rf_stall && !wide_mem[head];
      HI:      pop = !rf_stall;
      default: pop = 1'b0;
    endcase
  end

  always_ff @(posedge clock) begin
    if (push) begin
      rd_mem[tail]   <= ex.ex_rd;
      wide_mem[tail] <= ex.ex_wide;
      data_mem[tail] <= ex.ex_data;
    end
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      state        <= IDLE;
      wr_ptr       <= '0;
      rd_ptr       <= '0;
      retire_count <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + (PTR_W+1)'(1);
      if (pop) begin
        rd_ptr       <= rd_ptr + (PTR_W+1)'(1);
        retire_count <= retire_count + 32'd1;
      end
      case (state)
        IDLE: if (push) state <= LO;
        LO: begin
          if (!rf_stall) begin
            if (wide_mem[head]) state <= HI;
            else                state <= more ? LO : IDLE;
          end
        end
        HI: if (!rf_stall) state <= more ? LO : IDLE;
        default: state <= IDLE;
      endcase
    end
  end

  // Write port: x0 targets consume the cycle but never assert rf_we.
  always_comb begin
    rf_we    = 1'b0;
    rf_waddr = '0;
    rf_wdata = '0;
    case (state)
      LO: begin
        rf_waddr = head_rd;
        rf_wdata = data_mem[head][DATA_WIDTH-1:0];
        rf_we    = !rf_stall && (head_rd != '0);
      end
      HI: begin
        rf_waddr = head_rd1;
        rf_wdata = data_mem[head][2*DATA_WIDTH-1:DATA_WIDTH];
        rf_we    = !rf_stall && (head_rd1 != '0);
      end
      default: ;
    endcase
  end

  // Walk oldest to youngest so the youngest match overwrites older ones.
  always_comb begin
    q_hit  = 1'b0;
    q_data = '0;
    idx    = '0;
    for (int k = 0; k < DEPTH; k++) begin
      idx = head + PTR_W'(k);
      if ((int'(count) > k) && (q_addr != '0)) begin
        if (rd_mem[idx] == q_addr) begin
          q_hit  = 1'b1;
          q_data = data_mem[idx][DATA_WIDTH-1:0];
        end
        if (wide_mem[idx] && ((rd_mem[idx] + ONE) == q_addr)) begin
          q_hit  = 1'b1;
          q_data = data_mem[idx][2*DATA_WIDTH-1:DATA_WIDTH];
        end
      end
    end
  end
endmodule

// File: tb/tb_exwb_wb_drain.sv
// Bench for exwb_wb_drain: expected register writes are queued as results are
// driven and popped by a write monitor; forwarding is checked from a vector table.
module tb_exwb_wb_drain;
  localparam int DW    = 32;
  localparam int RAW   = 5;
  localparam int DEPTH = 2;
  localparam logic [RAW-1:0] ONE = RAW'(1);

  // clock / reset
  logic clock = 1'b0;
  logic reset = 1'b0;
  always #5 clock = ~clock;

  exwb_wb_drain_if #(.DATA_WIDTH(DW), .REG_ADDR_WIDTH(RAW)) ex ();
  logic           rf_stall;
  logic           rf_we;
  logic [RAW-1:0] rf_waddr;
  logic [DW-1:0]  rf_wdata;
  logic [RAW-1:0] q_addr;
  logic           q_hit;
  logic [DW-1:0]  q_data;
  logic [31:0]    retire_count;
  logic [1:0]     fsm_state;

  exwb_wb_drain #(.DATA_WIDTH(DW), .REG_ADDR_WIDTH(RAW), .DEPTH(DEPTH)) dut (
    .clock(clock), .reset(reset), .ex(ex), .rf_stall(rf_stall),
    .rf_we(rf_we), .rf_waddr(rf_waddr), .rf_wdata(rf_wdata),
    .q_addr(q_addr), .q_hit(q_hit), .q_data(q_data),
    .retire_count(retire_count), .fsm_state(fsm_state)
  );

  // scoreboard
  logic [RAW+DW-1:0] exp_q[$];
  int total = 0;
  int bad = 0;
  int exp_retire = 0;

  typedef struct {
    logic [RAW-1:0] q;
    logic           hit;
    logic [DW-1:0]  data;
  } fwd_vec_t;
  fwd_vec_t fv[6];

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  always @(negedge clock) begin
    logic [RAW+DW-1:0] e;
    if (reset && rf_we) begin
      total++;
      if (exp_q.size() == 0) begin
        bad++;
        $display("FAIL unexpected_write: addr=%0d data=%h with nothing expected", rf_waddr, rf_wdata);
      end else begin
        e = exp_q.pop_front();
        if ({rf_waddr, rf_wdata} !== e) begin
          bad++;
          $display("FAIL write: got r%0d=%h expected r%0d=%h", rf_waddr, rf_wdata, e[RAW+DW-1:DW], e[DW-1:0]);
        end
      end
    end
  end

  // driver: returns 1 time unit after the accepting edge
  task automatic push(input logic [RAW-1:0] rd, input logic wide, input logic [2*DW-1:0] data);
    int guard;
    logic [RAW-1:0] rd1;
    guard = 0;
    rd1 = rd + ONE;
    ex.ex_valid = 1'b1;
    ex.ex_rd    = rd;
    ex.ex_wide  = wide;
    ex.ex_data  = data;
    while (!ex.ex_ready && guard < 200) begin
      @(negedge clock);
      guard++;
    end
    total++;
    if (guard >= 200) begin
      bad++;
      $display("FAIL push_timeout: ex_ready=%0b after %0d cycles, need 1", ex.ex_ready, guard);
    end
    if (rd != '0) exp_q.push_back({rd, data[DW-1:0]});
    if (wide && rd1 != '0) exp_q.push_back({rd1, data[2*DW-1:DW]});
    exp_retire++;
    @(posedge clock);
    #1;
    ex.ex_valid = 1'b0;
  endtask

  task automatic drain(input string name);
    repeat (6) @(negedge clock);
    check({name, "_queue_empty"}, 64'(exp_q.size()), 64'd0);
    check({name, "_retire"}, 64'(retire_count), 64'(exp_retire));
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    fv[0] = '{q: 5'd9,  hit: 1'b1, data: 32'hB};
    fv[1] = '{q: 5'd10, hit: 1'b0, data: 32'h0};
    fv[2] = '{q: 5'd0,  hit: 1'b0, data: 32'h0};
    fv[3] = '{q: 5'd12, hit: 1'b1, data: 32'h66};
    fv[4] = '{q: 5'd13, hit: 1'b1, data: 32'h55};
    fv[5] = '{q: 5'd14, hit: 1'b0, data: 32'h0};

    ex.ex_valid = 1'b0;
    ex.ex_rd    = '0;
    ex.ex_wide  = 1'b0;
    ex.ex_data  = '0;
    rf_stall    = 1'b0;
    q_addr      = '0;

    // reset state
    repeat (3) @(negedge clock);
    check("rst_ex_ready", 64'(ex.ex_ready), 64'd1);
    check("rst_rf_we", 64'(rf_we), 64'd0);
    check("rst_rf_waddr", 64'(rf_waddr), 64'd0);
    check("rst_rf_wdata", 64'(rf_wdata), 64'd0);
    check("rst_q_hit", 64'(q_hit), 64'd0);
    check("rst_q_data", 64'(q_data), 64'd0);
    check("rst_retire", 64'(retire_count), 64'd0);
    reset = 1'b1;
    @(negedge clock);

    // narrow result, earliest latency
    push(5'd5, 1'b0, 64'h0_DEADBEEF);
    @(negedge clock);
    check("lat_rf_we", 64'(rf_we), 64'd1);
    check("lat_rf_waddr", 64'(rf_waddr), 64'd5);
    check("lat_rf_wdata", 64'(rf_wdata), 64'hDEADBEEF);
    check("lat_ex_ready", 64'(ex.ex_ready), 64'd1);
    drain("narrow");

    // wide result retires only after the high half
    push(5'd6, 1'b1, 64'h11112222_33334444);
    @(negedge clock);
    check("wide_lo_addr", 64'(rf_waddr), 64'd6);
    check("wide_lo_retire", 64'(retire_count), 64'd1);
    @(negedge clock);
    check("wide_hi_addr", 64'(rf_waddr), 64'd7);
    check("wide_hi_retire", 64'(retire_count), 64'd1);
    @(negedge clock);
    check("wide_done_retire", 64'(retire_count), 64'd2);
    drain("wide");

    // stall fills the buffer, third result held off
    rf_stall = 1'b1;
    push(5'd1, 1'b0, 64'h101);
    push(5'd2, 1'b0, 64'h202);
    check("full_ex_ready", 64'(ex.ex_ready), 64'd0);
    fork
      push(5'd3, 1'b0, 64'h303);
      begin
        repeat (3) @(negedge clock);
        check("stall_ex_ready", 64'(ex.ex_ready), 64'd0);
        check("stall_rf_we", 64'(rf_we), 64'd0);
        rf_stall = 1'b0;
      end
    join
    drain("stall");
    check("stall_ready_back", 64'(ex.ex_ready), 64'd1);

    // back-to-back narrow burst
    for (int i = 0; i < 8; i++)
      push(RAW'($urandom_range(1, 31)), 1'b0, {32'h0, 32'($urandom)});
    drain("burst");

    // x0 suppression and wrap of rd=31 wide
    push(5'd0, 1'b0, 64'h0_0BADBAD0);
    push(5'd31, 1'b1, 64'hCAFE0000_0000F00D);
    drain("x0");

    // forwarding, scenario A: two entries for r9
    rf_stall = 1'b1;
    push(5'd9, 1'b0, 64'hA);
    push(5'd9, 1'b0, 64'hB);
    for (int i = 0; i < 3; i++) begin
      q_addr = fv[i].q;
      #1;
      check($sformatf("fwd%0d_hit", i), 64'(q_hit), 64'(fv[i].hit));
      check($sformatf("fwd%0d_data", i), 64'(q_data), 64'(fv[i].data));
    end
    rf_stall = 1'b0;
    drain("fwd_a");

    // forwarding, scenario B: wide r12/r13 then younger narrow r13
    rf_stall = 1'b1;
    push(5'd12, 1'b1, 64'h77_00000066);
    push(5'd13, 1'b0, 64'h55);
    for (int i = 3; i < 6; i++) begin
      q_addr = fv[i].q;
      #1;
      check($sformatf("fwd%0d_hit", i), 64'(q_hit), 64'(fv[i].hit));
      check($sformatf("fwd%0d_data", i), 64'(q_data), 64'(fv[i].data));
    end
    rf_stall = 1'b0;
    drain("fwd_b");

    // head in HI still forwards its low half
    push(5'd20, 1'b1, 64'h2121_0000_2020);
    @(posedge clock);
    #1;
    rf_stall = 1'b1;
    q_addr = 5'd20;
    #1;
    check("hi_fwd_lo_hit", 64'(q_hit), 64'd1);
    check("hi_fwd_lo_data", 64'(q_data), 64'h2020);
    q_addr = 5'd21;
    #1;
    check("hi_fwd_hi_data", 64'(q_data), 64'h2121);
    rf_stall = 1'b0;
    drain("hi_fwd");

    // reset in HI with a second entry queued
    rf_stall = 1'b1;
    push(5'd3, 1'b1, 64'h3333_0000_3030);
    push(5'd4, 1'b0, 64'h4040);
    rf_stall = 1'b0;
    @(posedge clock);
    #1;
    reset = 1'b0;
    exp_q.delete();
    exp_retire = 0;
    q_addr = 5'd4;
    #1;
    check("mid_rst_rf_we", 64'(rf_we), 64'd0);
    check("mid_rst_rf_waddr", 64'(rf_waddr), 64'd0);
    check("mid_rst_rf_wdata", 64'(rf_wdata), 64'd0);
    check("mid_rst_q_hit", 64'(q_hit), 64'd0);
    check("mid_rst_q_data", 64'(q_data), 64'd0);
    check("mid_rst_ex_ready", 64'(ex.ex_ready), 64'd1);
    check("mid_rst_retire", 64'(retire_count), 64'd0);
    @(negedge clock);
    reset = 1'b1;
    drain("after_rst");

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
